pc_bus_master: RTL and testbench
================================

Name: pc_bus_master

Overview:
- Host-side controller for the 8-bit program-counter peripheral.
- Drives the peripheral's three control lines (count enable, load, output enable) and owns the other end of the shared 8-bit bidirectional bus.
- LOAD: drives a host byte onto the bus in the peripheral's capture window. READ: enables the peripheral's bus drive and samples the count.
- Sits between a simple valid/ready command port and the peripheral pins; guarantees no bus contention.

Parameters:
- SYNC_STAGES, 1: flop depth of the peripheral's control-input synchronizer (cycles from a control output change to the peripheral acting on it).
- TURN_CYC, 1: idle bus-turnaround cycles appended after every LOAD/READ before cmd_ready reasserts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle, command accepted when cmd_valid&cmd_ready at a rising edge.
- cmd_op  in  2  01=LOAD, 10=READ, 00/11=NOP.
- cmd_data  in  8  LOAD value.
- run_en  in  1  requested counting enable.
- rsp_valid  out  1  one-cycle READ result strobe.
- rsp_data  out  8  sampled count, held until the next READ.
- busy  out  1  equals ~cmd_ready.
- peer_en  out  1  peripheral count enable.
- peer_load  out  1  peripheral load request.
- peer_oe  out  1  peripheral bus output enable.
- bus_in  in  8  bus input path.
- bus_out  out  8  bus output path.
- bus_oe  out  8  bus drive enables, all bits equal.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=00, peer_en=0, peer_load=0, peer_oe=0, bus_out=00, bus_oe=00, state IDLE.
- Reset mid-operation aborts immediately and releases the bus.
- peer_en <= run_en every cycle, regardless of FSM state.
- Default bus ownership: neither side drives. peer_oe=0 and bus_oe=00 in IDLE.
- Command acceptance:
  - Only in IDLE.
  - NOP is accepted and dropped: no response, cmd_ready stays 1.
  - cmd_data is latched at acceptance.
- FSM states: IDLE, L_PULSE, L_WAIT, L_DRIVE, R_EN, R_HOLD, TURN.
- LOAD timing, accepted at edge E0 (S=SYNC_STAGES):
  - peer_load=1 for exactly one cycle (E0..E0+1), then 0.
  - peer_oe stays 0 throughout.
  - bus_out=data and bus_oe=FF from edge E0+S+1 to edge E0+S+3, which covers the peripheral's release and capture states.
  - The peripheral captures at edge E0+S+3.
  - bus_oe=00 after E0+S+3, then TURN for TURN_CYC cycles.
  - cmd_ready=1 after E0+S+3+TURN_CYC.
- READ timing, accepted at E0:
  - peer_oe=1 from E0 to E0+S+1.
  - rsp_data<=bus_in at E0+S+1, so the peripheral has driven the bus for one full cycle before sampling.
  - rsp_valid=1 for the single cycle after E0+S+1.
  - peer_oe=0 after E0+S+1.
  - Wait S cycles for the peripheral to stop driving, then TURN_CYC cycles.
  - cmd_ready=1 after E0+2S+1+TURN_CYC.
- Contention invariant: bus_oe!=00 implies peer_oe has been 0 for at least S+1 cycles.
- peer_load pulses are always separated by at least S+3 low cycles, so the peripheral's edge detector sees a fresh rising edge per LOAD.
- cmd_valid during busy is ignored: no queuing, and the host must hold the request.
- rsp_data is unaffected by LOAD.

Test Plan:
- Reset with cmd_valid=1 and op=LOAD held -> all outputs at reset values, bus_oe=00, peer_load=0 until rst_n rises.
- S=1, TURN=1, LOAD 0xA5 at E0 -> peer_load high only for E0..E0+1; bus_out=A5 with bus_oe=FF after E0+2 through E0+4; cmd_ready high after E0+5; peripheral model count=A5 after E0+4.
- S=1, run_en=0, peripheral count=3C, READ at E0 -> peer_oe high E0..E0+2; rsp_valid single pulse after E0+2 with rsp_data=3C; cmd_ready after E0+4.
- LOAD 0x10 then back-to-back READ with run_en=1 -> no cycle with both bus_oe=FF and peripheral driving; rsp_data = 0x10 + number of enabled cycles since capture.
- NOP, and cmd_valid pulsed while busy -> no rsp_valid, no peer_load, cmd_ready stays 1 for NOP; busy-time request is dropped.
- rst_n asserted mid-LOAD at E0+3 -> bus_oe=00 and peer_load=0 within the same cycle (asynchronous); cmd_ready=1 after release.

Source files
------------

// File: rtl/pc_bus_master.sv
// Host-side controller for the 8-bit program-counter peripheral: sequences LOAD/READ
// on the peripheral control lines and the shared bus so that both ends never drive at once.
module pc_bus_master #(
  parameter int SYNC_STAGES = 1,
  parameter int TURN_CYC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       run_en,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       peer_en,
  output logic       peer_load,
  output logic       peer_oe,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic [2:0] dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready; cmd_ready is
  // high only in IDLE, requests made while busy are not queued, and rsp_valid is a one-cycle
  // strobe with no back-pressure.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L_PULSE = 3'd1,
    L_WAIT  = 3'd2,
    L_DRIVE = 3'd3,
    R_EN    = 3'd4,
    R_HOLD  = 3'd5,
    TURN    = 3'd6
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [7:0] S_W     = 8'(SYNC_STAGES);
  localparam logic [7:0] S1_W    = 8'(SYNC_STAGES + 1);
  localparam logic [7:0] T_W     = 8'(TURN_CYC);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] data_q, data_n;
  logic       ready_n, rsp_valid_n, load_n, oe_n, op_done;
  logic [7:0] rsp_data_n, bout_n, boe_n;

  assign busy      = ~cmd_ready;
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    data_n      = data_q;
    ready_n     = cmd_ready;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    load_n      = peer_load;
    oe_n        = peer_oe;
    bout_n      = bus_out;
    boe_n       = bus_oe;
    op_done     = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_op == OP_LOAD) begin
          data_n  = cmd_data;
          load_n  = 1'b1;
          ready_n = 1'b0;
          cnt_n   = 8'd0;
          state_n = L_PULSE;
        end else if (cmd_valid && cmd_op == OP_READ) begin
          oe_n    = 1'b1;
          ready_n = 1'b0;
          cnt_n   = 8'd1;
          state_n = R_EN;
        end
      end
      L_PULSE: begin
        load_n = 1'b0;
        cnt_n  = 8'd1;
        if (SYNC_STAGES == 0) begin
          bout_n  = data_q;
          boe_n   = 8'hFF;
          state_n = L_DRIVE;
        end else begin
          state_n = L_WAIT;
        end
      end
      L_WAIT: begin
        if (cnt == S_W) begin
          bout_n  = data_q;
          boe_n   = 8'hFF;
          cnt_n   = 8'd1;
          state_n = L_DRIVE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      // Held for two edges: the peripheral's release state and its capture edge.
      L_DRIVE: begin
        if (cnt == 8'd2) begin
          bout_n  = 8'h00;
          boe_n   = 8'h00;
          op_done = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      R_EN: begin
        if (cnt == S1_W) begin
          rsp_data_n  = bus_in;
          rsp_valid_n = 1'b1;
          oe_n        = 1'b0;
          cnt_n       = 8'd1;
          if (SYNC_STAGES == 0) op_done = 1'b1;
          else                  state_n = R_HOLD;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      // The peripheral still drives until its synchronizer sees peer_oe drop.
      R_HOLD: begin
        if (cnt == S_W) op_done = 1'b1;
        else            cnt_n   = cnt + 8'd1;
      end
      TURN: begin
        if (cnt == T_W) begin
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (op_done) begin
      if (TURN_CYC == 0) begin
        ready_n = 1'b1;
        state_n = IDLE;
      end else begin
        cnt_n   = 8'd1;
        state_n = TURN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      data_q    <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      peer_en   <= 1'b0;
      peer_load <= 1'b0;
      peer_oe   <= 1'b0;
      bus_out   <= 8'h00;
      bus_oe    <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      cmd_ready <= ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      peer_en   <= run_en;
      peer_load <= load_n;
      peer_oe   <= oe_n;
      bus_out   <= bout_n;
      bus_oe    <= boe_n;
    end
  end

endmodule

// File: tb/tb_pc_bus_master.sv
// Bench for pc_bus_master: a small model of the counter peripheral sits on the shared bus;
// directed table vectors plus hand-timed LOAD/READ/reset sequences.
module tb_pc_bus_master;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, run_en, rsp_valid, busy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data, bus_in, bus_out, bus_oe;
  logic       peer_en, peer_load, peer_oe;
  logic [2:0] dbg_state;

  int checks, errors, load_rises, rsp_count, oe_low_cnt;
  logic       load_q;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pc_bus_master #(.SYNC_STAGES(1), .TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .run_en(run_en), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .peer_en(peer_en), .peer_load(peer_load),
    .peer_oe(peer_oe), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .dbg_state(dbg_state)
  );

  // Peripheral model: one-flop input synchronizer, load edge detect -> release -> capture.
  logic       en_s, load_s, load_prev, oe_s;
  logic [1:0] p_state;
  logic [7:0] p_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s <= 1'b0; load_s <= 1'b0; load_prev <= 1'b0; oe_s <= 1'b0;
      p_state <= 2'd0; p_count <= 8'h00;
    end else begin
      en_s      <= peer_en;
      load_s    <= peer_load;
      load_prev <= load_s;
      oe_s      <= peer_oe;
      if (p_state == 2'd2)   p_count <= bus_in;
      else if (en_s)         p_count <= p_count + 8'd1;
      case (p_state)
        2'd0:    if (load_s && !load_prev) p_state <= 2'd1;
        2'd1:    p_state <= 2'd2;
        default: p_state <= 2'd0;
      endcase
    end
  end

  always_comb begin
    if (oe_s && bus_oe != 8'h00) bus_in = 8'hxx;
    else if (oe_s)               bus_in = p_count;
    else if (bus_oe == 8'hFF)    bus_in = bus_out;
    else                         bus_in = 8'hzz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: response scoreboard, load pulse counter, bus contention invariant.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
      else                   chk("rsp_data_sb", 32'(rsp_data), 32'(exp_q.pop_front()));
    end
    if (peer_load && !load_q) load_rises++;
    load_q = peer_load;
    if (peer_oe) oe_low_cnt = 0;
    else if (oe_low_cnt < 1000) oe_low_cnt++;
    if (bus_oe != 8'h00)
      chk("contention", 32'(oe_low_cnt >= S + 1 && !oe_s), 32'd1);
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    logic took;
    took = 1'b0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      took = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; cmd_op = 2'b00;
    chk("accept", 32'(took), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] exp_rsp;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  localparam logic [31:0] RST_VAL = {2'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lr, rc;
    checks = 0; errors = 0; load_rises = 0; rsp_count = 0; oe_low_cnt = 1000; load_q = 1'b0;
    vecs[0]  = '{2'b01, 8'hA5, 8'h00};
    vecs[1]  = '{2'b10, 8'h00, 8'hA5};
    vecs[2]  = '{2'b00, 8'h11, 8'h00};
    vecs[3]  = '{2'b01, 8'h3C, 8'h00};
    vecs[4]  = '{2'b10, 8'h00, 8'h3C};
    vecs[5]  = '{2'b10, 8'h00, 8'h3C};
    vecs[6]  = '{2'b01, 8'hFF, 8'h00};
    vecs[7]  = '{2'b11, 8'h22, 8'h00};
    vecs[8]  = '{2'b10, 8'h00, 8'hFF};
    vecs[9]  = '{2'b01, 8'h00, 8'h00};
    vecs[10] = '{2'b10, 8'h00, 8'h00};
    vecs[11] = '{2'b01, 8'h81, 8'h00};
    vecs[12] = '{2'b10, 8'h00, 8'h81};

    // Reset held with a LOAD request pending.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h5A; run_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outputs", {2'b0, cmd_ready, busy, rsp_valid, rsp_data, peer_en, peer_load,
                            peer_oe, bus_out, bus_oe}, RST_VAL);
    end
    chk("reset_state", 32'(dbg_state), 32'd0);
    cmd_valid = 1'b0; cmd_op = 2'b00; run_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);

    // LOAD A5 cycle by cycle.
    send_cmd(2'b01, 8'hA5);
    chk("ld_k0_load", 32'(peer_load), 32'd1);
    chk("ld_k0_ready", 32'(cmd_ready), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("ld_peer_load", 32'(peer_load), 32'd0);
      chk("ld_peer_oe", 32'(peer_oe), 32'd0);
      chk("ld_bus_oe", 32'(bus_oe), (k == 2 || k == 3) ? 32'hFF : 32'h00);
      if (k == 2 || k == 3) chk("ld_bus_out", 32'(bus_out), 32'hA5);
      chk("ld_ready", 32'(cmd_ready), 32'(k >= 5));
      if (k >= 4) chk("ld_capture", 32'(p_count), 32'hA5);
    end

    // READ of 3C cycle by cycle.
    send_cmd(2'b01, 8'h3C);
    wait_idle();
    exp_q.push_back(8'h3C);
    send_cmd(2'b10, 8'h00);
    chk("rd_k0_oe", 32'(peer_oe), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("rd_peer_oe", 32'(peer_oe), 32'(k < 2));
      chk("rd_rsp_valid", 32'(rsp_valid), 32'(k == 2));
      if (k == 2) chk("rd_rsp_data", 32'(rsp_data), 32'h3C);
      chk("rd_ready", 32'(cmd_ready), 32'(k >= 4));
      chk("rd_bus_oe", 32'(bus_oe), 32'h00);
    end

    // Table of commands with run_en low.
    for (int i = 0; i < NV; i++) begin
      lr = load_rises;
      if (vecs[i].op == 2'b10) exp_q.push_back(vecs[i].exp_rsp);
      send_cmd(vecs[i].op, vecs[i].data);
      chk("vec_busy", 32'(busy), 32'(vecs[i].op == 2'b01 || vecs[i].op == 2'b10));
      wait_idle();
      chk("vec_load_pulses", 32'(load_rises - lr), 32'(vecs[i].op == 2'b01));
    end
    chk("vec_queue_drained", 32'(exp_q.size()), 32'd0);

    // LOAD 10 then back-to-back READ while counting: 3 enabled edges after capture.
    run_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.push_back(8'h13);
    send_cmd(2'b01, 8'h10);
    send_cmd(2'b10, 8'h00);
    wait_idle();
    chk("b2b_rsp", 32'(rsp_data), 32'h13);
    run_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    send_cmd(2'b01, 8'h55);
    wait_idle();
    chk("load_keeps_rsp", 32'(rsp_data), 32'h13);

    // NOPs, then a request pulsed while busy.
    lr = load_rises; rc = rsp_count;
    cmd_valid = 1'b1; cmd_op = 2'b00;
    @(posedge clk); #1;
    chk("nop00_ready", 32'(cmd_ready), 32'd1);
    cmd_op = 2'b11;
    @(posedge clk); #1;
    chk("nop11_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0; cmd_op = 2'b00;
    send_cmd(2'b01, 8'h66);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge clk); #1;
    chk("busy_during_pulse", 32'(busy), 32'd1);
    cmd_valid = 1'b0; cmd_op = 2'b00;
    wait_idle();
    repeat (4) begin
      @(posedge clk); #1;
      chk("busy_req_dropped", 32'(cmd_ready), 32'd1);
    end
    chk("nop_busy_loads", 32'(load_rises - lr), 32'd1);
    chk("nop_busy_rsps", 32'(rsp_count - rc), 32'd0);

    // Reset during the bus-drive phase of a LOAD.
    send_cmd(2'b01, 8'h77);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_ld_driving", 32'(bus_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bus_oe", 32'(bus_oe), 32'h00);
    chk("abort_peer_load", 32'(peer_load), 32'd0);
    chk("abort_peer_oe", 32'(peer_oe), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_abort_ready", 32'(cmd_ready), 32'd1);
    chk("after_abort_state", 32'(dbg_state), 32'd0);
    exp_q.push_back(8'h00);
    send_cmd(2'b10, 8'h00);
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
